// File: rtl/param_mailbox_if.sv
// Producer/consumer bus for param_mailbox: write side, read side, status and sticky errors.
interface param_mailbox_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic              clr_err;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, count, full, empty,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, count, full, empty,
             almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/param_mailbox.sv
// Single-clock mailbox of DEPTH entries (any DEPTH >= 2), registered read data,
// exact occupancy count, programmable thresholds and sticky overflow/underflow.
module param_mailbox #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int AF_LVL = DEPTH - 1,
   parameter int AE_LVL = 1,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input logic              clk,
   input logic              rst,
   param_mailbox_if.slave   mb
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LVL);
   localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LVL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              full_w;
   logic              empty_w;
   logic              wr_acc;
   logic              rd_acc;

   always_comb begin
      full_w  = (count_q == DEPTH_C);
      empty_w = (count_q == '0);
      rd_acc  = mb.rd_en && !empty_w;
      // a pop in the same cycle frees a slot, so a full mailbox still accepts the write
      wr_acc  = mb.wr_en && (!full_w || rd_acc);
   end

   assign mb.count        = count_q;
   assign mb.full         = full_w;
   assign mb.empty        = empty_w;
   assign mb.almost_full  = (count_q >= AF_C);
   assign mb.almost_empty = (count_q <= AE_C);
   assign mb.rd_data      = rd_data_q;
   assign mb.rd_valid     = rd_valid_q;
   assign mb.overflow     = overflow_q;
   assign mb.underflow    = underflow_q;

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wp] <= mb.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp          <= '0;
         rp          <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= mem[rp];
            rp        <= (rp == PTR_LAST) ? '0 : rp + PTR_W'(1);
         end
         if (wr_acc) begin
            wp <= (wp == PTR_LAST) ? '0 : wp + PTR_W'(1);
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (mb.wr_en && !wr_acc) begin
            overflow_q <= 1'b1;
         end else if (mb.clr_err) begin
            overflow_q <= 1'b0;
         end
         if (mb.rd_en && !rd_acc) begin
            underflow_q <= 1'b1;
         end else if (mb.clr_err) begin
            underflow_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_param_mailbox.sv
// Drives three mailbox configurations with shared stimulus; a queue model per
// instance predicts status, and a monitor scoreboards popped data.
module tb_param_mailbox;
   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [7:0] wd;
   logic       re;
   logic       ce;

   always #5 clk = ~clk;

   param_mailbox_if #(.DATA_W(8), .DEPTH(8)) if0 ();
   param_mailbox_if #(.DATA_W(8), .DEPTH(5)) if1 ();
   param_mailbox_if #(.DATA_W(8), .DEPTH(8)) if2 ();

   param_mailbox #(.DATA_W(8), .DEPTH(8)) u0 (.clk(clk), .rst(rst), .mb(if0));
   param_mailbox #(.DATA_W(8), .DEPTH(5)) u1 (.clk(clk), .rst(rst), .mb(if1));
   param_mailbox #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2)) u2 (.clk(clk), .rst(rst), .mb(if2));

   assign if0.wr_en = we;  assign if0.wr_data = wd;  assign if0.rd_en = re;  assign if0.clr_err = ce;
   assign if1.wr_en = we;  assign if1.wr_data = wd;  assign if1.rd_en = re;  assign if1.clr_err = ce;
   assign if2.wr_en = we;  assign if2.wr_data = wd;  assign if2.rd_en = re;  assign if2.clr_err = ce;

   logic [7:0] rdd [3];
   logic       rv  [3];
   logic [3:0] cnt [3];
   logic [5:0] flg [3];

   assign rdd[0] = if0.rd_data;  assign rv[0] = if0.rd_valid;  assign cnt[0] = if0.count;
   assign rdd[1] = if1.rd_data;  assign rv[1] = if1.rd_valid;  assign cnt[1] = {1'b0, if1.count};
   assign rdd[2] = if2.rd_data;  assign rv[2] = if2.rd_valid;  assign cnt[2] = if2.count;
   assign flg[0] = {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow, if0.underflow};
   assign flg[1] = {if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow, if1.underflow};
   assign flg[2] = {if2.full, if2.empty, if2.almost_full, if2.almost_empty, if2.overflow, if2.underflow};

   int depth_p [3] = '{8, 5, 8};
   int af_p    [3] = '{7, 4, 6};
   int ae_p    [3] = '{1, 1, 2};

   logic [7:0] mdl  [3][$];
   logic [7:0] expq [3][$];
   bit         ovf_m [3];
   bit         udf_m [3];
   bit         exprv [3];
   logic [7:0] mon_last [3];
   bit         started = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   task automatic step(input logic w, input logic [7:0] wd_i, input logic r_i,
                       input logic c_i, input logic rs_i);
      we = w; wd = wd_i; re = r_i; ce = c_i; rst = rs_i;
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         int  n;
         bit  ra, wa;
         n = mdl[d].size();
         if (rs_i) begin
            mdl[d].delete();
            expq[d].delete();
            ovf_m[d] = 1'b0;
            udf_m[d] = 1'b0;
            exprv[d] = 1'b0;
            mon_last[d] = 8'h00;
         end else begin
            ra = r_i && (n > 0);
            wa = w && ((n < depth_p[d]) || ra);
            if (ra) expq[d].push_back(mdl[d].pop_front());
            if (wa) mdl[d].push_back(wd_i);
            if (w && !wa) ovf_m[d] = 1'b1;
            else if (c_i) ovf_m[d] = 1'b0;
            if (r_i && !ra) udf_m[d] = 1'b1;
            else if (c_i) udf_m[d] = 1'b0;
            exprv[d] = ra;
         end
      end
      started = 1'b1;
      #1;
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int d = 0; d < 3; d++) begin
            int n;
            n = mdl[d].size();
            chk($sformatf("d%0d_count", d), int'(cnt[d]), n);
            chk($sformatf("d%0d_full", d), int'(flg[d][5]), int'(n == depth_p[d]));
            chk($sformatf("d%0d_empty", d), int'(flg[d][4]), int'(n == 0));
            chk($sformatf("d%0d_almost_full", d), int'(flg[d][3]), int'(n >= af_p[d]));
            chk($sformatf("d%0d_almost_empty", d), int'(flg[d][2]), int'(n <= ae_p[d]));
            chk($sformatf("d%0d_overflow", d), int'(flg[d][1]), int'(ovf_m[d]));
            chk($sformatf("d%0d_underflow", d), int'(flg[d][0]), int'(udf_m[d]));
            chk($sformatf("d%0d_rd_valid", d), int'(rv[d]), int'(exprv[d]));
            if (rv[d] === 1'b1) begin
               if (expq[d].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL d%0d_unexpected_pop at %0t: got %0h expected no data", d, $time, rdd[d]);
               end else begin
                  mon_last[d] = expq[d].pop_front();
               end
            end
            chk($sformatf("d%0d_rd_data", d), int'(rdd[d]), int'(mon_last[d]));
         end
      end
   end

   initial begin
      we = 1'b0; wd = 8'h00; re = 1'b0; ce = 1'b0; rst = 1'b1;
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1);

      // reset/basic
      step(1, 8'hAA, 0, 0, 0);
      step(1, 8'h55, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0);

      // fill past full, drain, clear
      for (int i = 0; i < 9; i++) step(1, 8'(i), 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);

      // wrap pattern
      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);

      // simultaneous ops at full and at empty
      for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
      step(1, 8'hEE, 1, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);
      step(1, 8'h77, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);

      // threshold staircase up and down
      for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

      // reset with a read in flight
      for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 0, 1);
      step(0, 8'h00, 0, 0, 0);

      // clr_err and new error together: set wins
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 1, 0);

      for (int k = 0; k < 2000; k++) begin
         step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
              $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
      end

      for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_pending_pops", d), expq[d].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/param_mailbox.md
# param_mailbox

Parametrised single-clock mailbox with registered read data, exact occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. All DEPTH entries are usable, so no slot is sacrificed to tell full from empty. It sits between a producer and a consumer testbench component and is the general-purpose successor to the fixed 8x8 mailbox.

## Interface
- DATA_W, 8, width of each mailbox entry (>=1)
- DEPTH, 8, number of entries; any integer >=2, not restricted to powers of two
- AF_LVL, DEPTH-1, almost_full asserts when count >= AF_LVL (1..DEPTH)
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL (0..DEPTH-1)
- CNT_W, $clog2(DEPTH+1), width of count (derived; do not override)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse: rd_data holds a newly popped entry
- count  out  CNT_W  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LVL
- almost_empty  out  1  count <= AE_LVL
- overflow  out  1  sticky: write attempted and rejected
- underflow  out  1  sticky: read attempted and rejected
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH x DATA_W array; write pointer wp, read pointer rp, occupancy register count.
- Write accepted (wr_acc) when wr_en && (!full || rd_acc). Stores wr_data at mem[wp]; wp advances.
- Read accepted (rd_acc) when rd_en && !empty. rd_data <= mem[rp]; rp advances; rd_valid = 1 next cycle.
- Pointer wrap: DEPTH-1 -> 0 explicitly. Modulo arithmetic that assumes a power-of-two DEPTH is not permitted.
- count next = count + wr_acc - rd_acc.
- Full with wr_en && rd_en: both accepted; count stays DEPTH; no overflow.
- Empty with wr_en && rd_en: write accepted, read rejected (no fall-through); count -> 1; underflow set.
- Write rejected (full, no rd_acc): data dropped; overflow <= 1.
- Read rejected (empty): rd_data holds; rd_valid = 0; underflow <= 1.
- clr_err clears both sticky flags. If a new error occurs in the same cycle, set wins.
- rd_data holds its last value whenever no read is accepted.
- Reset: wp = rp = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0.
- Reset outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (AF_LVL >= 1).
- Memory contents are not reset.
- Reset mid-operation: all contents discarded, and any read pending that cycle produces no rd_valid.

## Timing
- Flags and count are decoded from the registered count, so they reflect operations accepted on the previous edge.
- Write-to-read latency: an entry written at edge N is readable (empty = 0) after edge N. rd_en in cycle N+1 gives rd_data/rd_valid after edge N+2.
- Read latency: 1 cycle from rd_acc to rd_valid.
- Back-to-back reads: one pop per cycle; rd_valid stays high continuously.
- Throughput: one write and one read per cycle sustained in any non-empty state.
- Reset takes effect at the first rising edge with rst = 1 and dominates all other inputs.

## Test plan
- Reset/basic: rst 2 cycles, then write 0xAA, 0x55, then read twice -> rd_data 0xAA then 0x55 with rd_valid; count 0->1->2->1->0; empty = 1 at end.
- Fill/overflow, DEPTH=8: write 0x00..0x08 (9 writes) -> full after the 8th, count = 8, overflow = 1. Drain 8 reads -> 0x00..0x07, no 0x08. clr_err -> overflow = 0.
- Non-power-of-two wrap, DEPTH=5: 3 writes, 3 reads, then 5 writes 0x10..0x14 and 5 reads -> order preserved across wrap; full asserted exactly at count 5.
- Simultaneous ops: at full, wr_en && rd_en with 0xEE -> count stays 8, no overflow, 0xEE is read last. At empty, wr_en && rd_en -> count = 1, underflow = 1, rd_valid = 0.
- Thresholds, DEPTH=8, AF_LVL=6, AE_LVL=2: step count 0..8 -> almost_empty = 1 for 0..2; almost_full = 1 for 6..8.
- Reset mid-operation: count = 4 with a read in flight, assert rst -> next cycle count = 0, empty = 1, rd_valid = 0, rd_data = 0, flags cleared.
